// File: rtl/vend_scheduler.sv
// Dispense motor scheduler: queues coin credits, round-robins them against maintenance
// test-vends, runs the motor start/done handshake and latches timeout/overflow faults.
module vend_scheduler #(
   parameter int unsigned CREDIT_MAX     = 7,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES     = 4,
   localparam int unsigned PW = $clog2(CREDIT_MAX + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dispense,
   input  logic          serviceReq,
   input  logic          motorDone,
   output logic          motorStart,
   output logic          serviceAck,
   output logic [PW-1:0] pending,
   output logic          busy,
   output logic          overflow,
   output logic          fault
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int unsigned CW = $clog2(CNT_MAX + 1);

   localparam logic [2:0] StIdle       = 3'd0;
   localparam logic [2:0] StRunCredit  = 3'd1;
   localparam logic [2:0] StRunService = 3'd2;
   localparam logic [2:0] StGap        = 3'd3;
   localparam logic [2:0] StFault      = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pending_d;
   logic          prefer_svc_q, prefer_svc_d;
   logic          disp_q, edge_q;
   logic          overflow_d, fault_d, ack_d, start_d, busy_d, dec;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      prefer_svc_d = prefer_svc_q;
      pending_d    = pending;
      overflow_d   = overflow;
      fault_d      = fault;
      ack_d        = 1'b0;
      dec          = 1'b0;

      case (state_q)
         StIdle: begin
            // Credit wins unless service is also asking and it is service's turn.
            if ((pending != '0) && !(serviceReq && prefer_svc_q)) begin
               state_d = StRunCredit;
               cnt_d   = '0;
            end else if (serviceReq) begin
               state_d = StRunService;
               cnt_d   = '0;
            end
         end
         StRunCredit, StRunService: begin
            if (motorDone) begin
               state_d = StGap;
               cnt_d   = '0;
               if (state_q == StRunCredit) begin
                  dec          = 1'b1;
                  prefer_svc_d = 1'b1;
               end else begin
                  ack_d        = 1'b1;
                  prefer_svc_d = 1'b0;
               end
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d = StFault;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StGap: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StFault: ;
         default: state_d = StIdle;
      endcase

      if (edge_q && !dec) begin
         if (pending == PW'(CREDIT_MAX)) overflow_d = 1'b1;
         else                            pending_d  = pending + PW'(1);
      end else if (dec && !edge_q && (pending != '0)) begin
         pending_d = pending - PW'(1);
      end

      start_d = (state_d == StRunCredit) || (state_d == StRunService);
      busy_d  = start_d || (state_d == StGap);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         prefer_svc_q <= 1'b0;
         disp_q       <= 1'b0;
         edge_q       <= 1'b0;
         pending      <= '0;
         motorStart   <= 1'b0;
         serviceAck   <= 1'b0;
         busy         <= 1'b0;
         overflow     <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         prefer_svc_q <= prefer_svc_d;
         disp_q       <= dispense;
         edge_q       <= dispense & ~disp_q;
         pending      <= pending_d;
         motorStart   <= start_d;
         serviceAck   <= ack_d;
         busy         <= busy_d;
         overflow     <= overflow_d;
         fault        <= fault_d;
      end
   end

endmodule
